// File: rtl/aes_sbox_arb.sv
// Byte-serial AES S-box sequencer with a two-way round-robin arbiter.
// One shared combinational S-box is stepped LSB-first, one byte per cycle.
module aes_sbox_arb #(
    parameter int BYTES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [8*BYTES-1:0]   req0_word,
    input  logic                 req0_inv,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [8*BYTES-1:0]   req1_word,
    input  logic                 req1_inv,
    output logic                 rsp0_valid,
    output logic                 rsp1_valid,
    output logic [8*BYTES-1:0]   rsp_word,
    output logic                 sbox_sub,
    output logic [7:0]           sbox_in,
    output logic                 sbox_inv,
    input  logic [7:0]           sbox_out
);

    localparam int W  = 8 * BYTES;
    localparam int CW = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt;
    logic            last_grant;
    logic [W-1:0]    word_q;
    logic [W-1:0]    acc_q;
    logic [W-1:0]    acc_next;
    logic            inv_q;
    logic            owner_q;
    logic            accept_ok;
    logic            grant0;
    logic            grant1;
    logic            accept;
    logic            last_byte;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        sbox_sub   = 1'b0;
        sbox_in    = '0;
        sbox_inv   = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        acc_next   = acc_q;

        // ready is forced low while reset is held, even though state is already IDLE
        accept_ok  = !rst && (state != BUSY);
        grant0     = req0_valid && (!req1_valid || last_grant);
        grant1     = req1_valid && (!req0_valid || !last_grant);
        req0_ready = accept_ok && grant0;
        req1_ready = accept_ok && grant1;
        accept     = req0_ready || req1_ready;
        last_byte  = (cnt == CW'(BYTES - 1));

        case (state)
            IDLE: begin
                if (accept) state_next = BUSY;
            end
            BUSY: begin
                sbox_sub = 1'b1;
                sbox_in  = word_q[{cnt, 3'b000} +: 8];
                sbox_inv = inv_q;
                acc_next[{cnt, 3'b000} +: 8] = sbox_out;
                if (last_byte) state_next = RESP;
            end
            RESP: begin
                rsp0_valid = !owner_q;
                rsp1_valid = owner_q;
                state_next = accept ? BUSY : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Assembly stays in acc_q; rsp_word only loads on entry to RESP so a
    // back-to-back capture in RESP cannot disturb the word being returned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            last_grant <= 1'b1;
            word_q     <= '0;
            acc_q      <= '0;
            rsp_word   <= '0;
            inv_q      <= 1'b0;
            owner_q    <= 1'b0;
        end else if (accept) begin
            word_q     <= req1_ready ? req1_word : req0_word;
            inv_q      <= req1_ready ? req1_inv : req0_inv;
            owner_q    <= req1_ready;
            last_grant <= req1_ready;
            cnt        <= '0;
        end else if (state == BUSY) begin
            acc_q <= acc_next;
            cnt   <= cnt + 1'b1;
            if (last_byte) rsp_word <= acc_next;
        end
    end

endmodule

// File: tb/tb_aes_sbox_arb.sv
// Testbench for aes_sbox_arb: S-box built from GF(2^8) arithmetic, queue-driven
// requesters and a phase-level reference model checked every cycle.
module tb_aes_sbox_arb;

    localparam int BYTES = 4;
    localparam int W     = 8 * BYTES;

    typedef struct {
        logic [W-1:0] w;
        logic         inv;
    } req_t;

    typedef struct {
        int           owner;
        logic [W-1:0] w;
        int           cyc;
    } rsp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           req0_valid, req0_ready, req0_inv;
    logic           req1_valid, req1_ready, req1_inv;
    logic [W-1:0]   req0_word, req1_word;
    logic           rsp0_valid, rsp1_valid;
    logic [W-1:0]   rsp_word;
    logic           sbox_sub, sbox_inv;
    logic [7:0]     sbox_in, sbox_out;

    logic [7:0]     fwd_t [256];
    logic [7:0]     inv_t [256];

    int             tests = 0;
    int             fails = 0;
    int             cyc   = 0;

    req_t           q0[$];
    req_t           q1[$];
    rsp_t           log_q[$];

    int             m_phase;
    logic           m_last;
    logic [W-1:0]   m_word;
    logic           m_inv;
    int             m_owner;
    int             m_rsp_owner;
    logic [W-1:0]   m_rsp_word;

    aes_sbox_arb #(.BYTES(BYTES)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_word  (req0_word),
        .req0_inv   (req0_inv),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_word  (req1_word),
        .req1_inv   (req1_inv),
        .rsp0_valid (rsp0_valid),
        .rsp1_valid (rsp1_valid),
        .rsp_word   (rsp_word),
        .sbox_sub   (sbox_sub),
        .sbox_in    (sbox_in),
        .sbox_inv   (sbox_inv),
        .sbox_out   (sbox_out)
    );

    always #5 clk = ~clk;

    // Garbage outside BUSY exposes any sampling of sbox_out when not enabled
    assign sbox_out = sbox_sub ? (sbox_inv ? inv_t[sbox_in] : fwd_t[sbox_in]) : 8'ha5;

    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rol8(logic [7:0] v, int n);
        logic [15:0] d;
        d = {v, v} << n;
        return d[15:8];
    endfunction

    task automatic build_tables();
        logic [7:0] b, s;
        for (int x = 0; x < 256; x++) begin
            b = '0;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
            s = b ^ rol8(b, 1) ^ rol8(b, 2) ^ rol8(b, 3) ^ rol8(b, 4) ^ 8'h63;
            fwd_t[x] = s;
            inv_t[s] = 8'(x);
        end
    endtask

    function automatic logic [W-1:0] sub_word(logic [W-1:0] w, logic inv);
        logic [W-1:0] r;
        for (int i = 0; i < BYTES; i++)
            r[8*i +: 8] = inv ? inv_t[w[8*i +: 8]] : fwd_t[w[8*i +: 8]];
        return r;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase     = -1;
        m_last      = 1'b1;
        m_word      = '0;
        m_inv       = 1'b0;
        m_owner     = 0;
        m_rsp_owner = 0;
        m_rsp_word  = '0;
    endtask

    // One clock cycle: drive from queues, check all outputs, advance the model
    task automatic cycle();
        logic         can, e_r0, e_r1, e_sub, e_inv;
        logic [7:0]   e_in;
        logic [W-1:0] sh;
        req0_valid = (q0.size() != 0);
        req0_word  = req0_valid ? q0[0].w   : W'($urandom);
        req0_inv   = req0_valid ? q0[0].inv : 1'($urandom);
        req1_valid = (q1.size() != 0);
        req1_word  = req1_valid ? q1[0].w   : W'($urandom);
        req1_inv   = req1_valid ? q1[0].inv : 1'($urandom);

        can = (m_phase < 0) || (m_phase == BYTES);
        if (req0_valid && req1_valid) begin
            e_r0 = can && m_last;
            e_r1 = can && !m_last;
        end else begin
            e_r0 = can && req0_valid;
            e_r1 = can && req1_valid;
        end
        e_sub = (m_phase >= 0) && (m_phase < BYTES);
        e_in  = 8'h00;
        if (e_sub) begin
            sh   = m_word >> (8 * m_phase);
            e_in = sh[7:0];
        end
        e_inv = e_sub && m_inv;

        #1;
        chk("req0_ready", 64'(req0_ready), 64'(e_r0));
        chk("req1_ready", 64'(req1_ready), 64'(e_r1));
        chk("sbox_sub",   64'(sbox_sub),   64'(e_sub));
        chk("sbox_in",    64'(sbox_in),    64'(e_in));
        chk("sbox_inv",   64'(sbox_inv),   64'(e_inv));
        chk("rsp0_valid", 64'(rsp0_valid), 64'(m_phase == BYTES && m_rsp_owner == 0));
        chk("rsp1_valid", 64'(rsp1_valid), 64'(m_phase == BYTES && m_rsp_owner == 1));
        chk("rsp_word",   64'(rsp_word),   64'(m_rsp_word));
        if (rsp0_valid || rsp1_valid)
            log_q.push_back('{owner: (rsp1_valid ? 1 : 0), w: rsp_word, cyc: cyc});

        @(posedge clk);
        if (e_r0 || e_r1) begin
            m_owner = e_r1 ? 1 : 0;
            m_word  = e_r1 ? q1[0].w : q0[0].w;
            m_inv   = e_r1 ? q1[0].inv : q0[0].inv;
            m_last  = e_r1;
            m_phase = 0;
            if (e_r1) void'(q1.pop_front());
            else      void'(q0.pop_front());
        end else if (m_phase == BYTES - 1) begin
            m_phase     = BYTES;
            m_rsp_word  = sub_word(m_word, m_inv);
            m_rsp_owner = m_owner;
        end else if (m_phase >= 0 && m_phase < BYTES - 1) begin
            m_phase++;
        end else if (m_phase == BYTES) begin
            m_phase = -1;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_until_idle(int maxc);
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || m_phase != -1) && n < maxc) begin
            cycle();
            n++;
        end
        chk("idle_timeout", 64'(n < maxc), 64'(1));
    endtask

    initial begin
        int base, c0, n;
        build_tables();
        model_reset();
        rst        = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_word  = 32'h12345678;
        req1_word  = 32'h9abcdef0;
        req0_inv   = 1'b0;
        req1_inv   = 1'b1;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready0",   64'(req0_ready), 64'(0));
        chk("rst_ready1",   64'(req1_ready), 64'(0));
        chk("rst_rsp0",     64'(rsp0_valid), 64'(0));
        chk("rst_rsp1",     64'(rsp1_valid), 64'(0));
        chk("rst_rsp_word", 64'(rsp_word),   64'(0));
        chk("rst_sbox_sub", 64'(sbox_sub),   64'(0));
        chk("rst_sbox_in",  64'(sbox_in),    64'(0));
        chk("rst_sbox_inv", 64'(sbox_inv),   64'(0));
        @(negedge clk);
        rst = 1'b0;

        // Tie from reset: requester 0 wins first, then strict alternation
        base = log_q.size();
        repeat (2) begin
            q0.push_back('{w: 32'hffffffff, inv: 1'b0});
            q1.push_back('{w: 32'h00000000, inv: 1'b1});
        end
        run_until_idle(60);
        chk("tie_count", 64'(log_q.size() - base), 64'(4));
        if (log_q.size() - base == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("tie_owner", 64'(log_q[base+k].owner), 64'(k % 2));
                chk("tie_word",  64'(log_q[base+k].w),
                    (k % 2 == 0) ? 64'h16161616 : 64'h52525252);
            end
        end

        // Forward substitution with latency check
        base = log_q.size();
        c0   = cyc;
        q0.push_back('{w: 32'h00010203, inv: 1'b0});
        run_until_idle(20);
        chk("fwd_count", 64'(log_q.size() - base), 64'(1));
        if (log_q.size() > base) begin
            chk("fwd_word",    64'(log_q[base].w),       64'h637c777b);
            chk("fwd_owner",   64'(log_q[base].owner),   64'(0));
            chk("fwd_latency", 64'(log_q[base].cyc - c0), 64'(BYTES + 1));
        end

        // Inverse substitution on requester 1
        base = log_q.size();
        q1.push_back('{w: 32'h637c777b, inv: 1'b1});
        run_until_idle(20);
        chk("inv_count", 64'(log_q.size() - base), 64'(1));
        if (log_q.size() > base) begin
            chk("inv_word",  64'(log_q[base].w),     64'h00010203);
            chk("inv_owner", 64'(log_q[base].owner), 64'(1));
        end

        // Back-to-back on one requester: accepted in RESP, results 5 cycles apart
        base = log_q.size();
        q0.push_back('{w: 32'h53535353, inv: 1'b0});
        q0.push_back('{w: 32'h00000000, inv: 1'b0});
        run_until_idle(30);
        chk("b2b_count", 64'(log_q.size() - base), 64'(2));
        if (log_q.size() - base == 2) begin
            chk("b2b_word0", 64'(log_q[base].w),   64'hedededed);
            chk("b2b_word1", 64'(log_q[base+1].w), 64'h63636363);
            chk("b2b_gap",   64'(log_q[base+1].cyc - log_q[base].cyc), 64'(BYTES + 1));
        end

        // Quiet period
        base = log_q.size();
        repeat (20) cycle();
        chk("quiet_no_rsp", 64'(log_q.size()), 64'(base));

        // Reset in the middle of BUSY at byte 2
        base = log_q.size();
        q0.push_back('{w: W'($urandom), inv: 1'($urandom)});
        n = 0;
        while (m_phase != 2 && n < 20) begin
            cycle();
            n++;
        end
        chk("midrst_reach", 64'(m_phase), 64'(2));
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rst = 1'b1;
        #1;
        chk("midrst_sub",      64'(sbox_sub),   64'(0));
        chk("midrst_in",       64'(sbox_in),    64'(0));
        chk("midrst_inv",      64'(sbox_inv),   64'(0));
        chk("midrst_rsp_word", 64'(rsp_word),   64'(0));
        chk("midrst_ready0",   64'(req0_ready), 64'(0));
        chk("midrst_ready1",   64'(req1_ready), 64'(0));
        repeat (BYTES) begin
            @(negedge clk);
            #1;
            chk("midrst_rsp0", 64'(rsp0_valid), 64'(0));
            chk("midrst_rsp1", 64'(rsp1_valid), 64'(0));
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("midrst_no_rsp", 64'(log_q.size()), 64'(base));

        // Post-reset tie: last_grant is back to its reset value, so req0 first
        base = log_q.size();
        q0.push_back('{w: W'($urandom), inv: 1'b0});
        q1.push_back('{w: W'($urandom), inv: 1'b1});
        run_until_idle(30);
        chk("post_rst_count", 64'(log_q.size() - base), 64'(2));
        if (log_q.size() - base == 2) begin
            chk("post_rst_owner0", 64'(log_q[base].owner),   64'(0));
            chk("post_rst_owner1", 64'(log_q[base+1].owner), 64'(1));
        end

        // Randomised traffic on both requesters
        repeat (400) begin
            if ($urandom_range(0, 3) == 0 && q0.size() < 3)
                q0.push_back('{w: W'($urandom), inv: 1'($urandom)});
            if ($urandom_range(0, 3) == 0 && q1.size() < 3)
                q1.push_back('{w: W'($urandom), inv: 1'($urandom)});
            cycle();
        end
        run_until_idle(200);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, time %0t", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/aes_sbox_arb.md
# aes_sbox_arb

Byte-serial sequencer and round-robin arbiter that shares one combinational AES S-box between two requesters, for example the aes32 execute path and the key-schedule unit. It accepts a 32-bit word, feeds the S-box one byte per cycle with `sub` asserted, assembles the substituted word, and returns it with a one-cycle response pulse. It sits between the requesters and a single S-box instance, which drives `sbox_out` combinationally from `sbox_in`/`sbox_inv` while `sbox_sub`=1.

## Interface
- `BYTES`, default 4: bytes per word; word width is 8*BYTES; byte counter is clog2(BYTES) bits.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req0_valid` in 1: requester 0 has a word to substitute.
- `req0_ready` out 1: requester 0 accepted this cycle.
- `req0_word` in 8*BYTES: requester 0 input word.
- `req0_inv` in 1: requester 0 wants the inverse S-box.
- `req1_valid`, `req1_ready`, `req1_word`, `req1_inv`: same as requester 0, for requester 1.
- `rsp0_valid` out 1: one-cycle pulse, result for requester 0.
- `rsp1_valid` out 1: one-cycle pulse, result for requester 1.
- `rsp_word` out 8*BYTES: shared result word, valid while either rsp pulse is high.
- `sbox_sub` out 1: S-box enable.
- `sbox_in` out 8: byte to S-box.
- `sbox_inv` out 1: inverse select to S-box.
- `sbox_out` in 8: S-box result.

## Operation
- States:
  - IDLE: waiting for a request.
  - BUSY: stepping byte counter `cnt` from 0 to BYTES-1.
  - RESP: response cycle.
- Acceptance:
  - Allowed only in IDLE or RESP, so back-to-back requests work.
  - Grant rule:
    - Only one valid: that requester is granted.
    - Both valid: the requester that is not `last_grant` is granted.
  - `reqN_ready` is combinational and equals accept-allowed & `reqN_valid` & granted N; at most one ready is high.
  - On accept, capture the word, `inv`, and owner id; set `last_grant`=N; clear `cnt`; go to BUSY.
- BUSY:
  - Drive `sbox_sub`=1, `sbox_inv`=captured inv, `sbox_in`=word[8*cnt +: 8]. Byte 0 (LSB) goes first.
  - Each edge: result[8*cnt +: 8] <= `sbox_out`, then `cnt`++.
  - At `cnt`=BYTES-1: go to RESP.
- RESP:
  - Raise `rsp<owner>_valid` for exactly one cycle; `rsp_word`=assembled result.
  - Next state: BUSY if a new request is accepted this cycle, otherwise IDLE.
- Outside BUSY: `sbox_sub`=0, `sbox_in`=0, `sbox_inv`=0. `sbox_out` is never sampled outside BUSY.
- `rsp_word` holds its last value until the next RESP.
- Responses have no backpressure; the requester must sample on the pulse.
- Request signals are don't-care while `ready`=0. A requester holds `valid`, `word` and `inv` stable until ready.

## Timing
- Reset values:
  - state=IDLE, `cnt`=0, `last_grant`=1 (requester 0 wins the first tie).
  - `rsp_word`=0, both rsp_valid=0, `sbox_sub`=0, `sbox_in`=0, `sbox_inv`=0.
  - Both ready=0 during reset.
- Latency: accept at edge E; BUSY occupies cycles E+1..E+BYTES; rsp pulse in cycle E+BYTES+1 (cycle 5 for BYTES=4).
- Throughput: one word per BYTES+1 cycles with back-to-back acceptance in RESP.
- A request that is valid while the block is in BUSY waits; ready stays 0.
- Simultaneous RESP and new accept: the old owner's pulse and the new grant happen in the same cycle. The captured word does not corrupt `rsp_word` that cycle, because assembly goes into an internal register and `rsp_word` is updated on entry to RESP.
- Reset mid-operation: abort with no response pulse and return to reset values. The in-flight request is lost; the requester must reissue.
- A single requester that is continuously valid is re-granted every RESP; `last_grant` only matters for ties.

## Test plan
- Forward: req0 word=0x00010203, inv=0 → `sbox_in` sequence 03,02,01,00 with `sbox_sub`=1 for 4 cycles; `rsp0_valid` in cycle 5; `rsp_word`=0x637c777b.
- Inverse: req1 word=0x637c777b, inv=1 → `sbox_inv`=1 during BUSY; `rsp1_valid` pulse; `rsp_word`=0x00010203; `rsp0_valid` stays 0.
- Tie/fairness: both requesters valid from reset with 0xffffffff(fwd) and 0x00000000(inv) → req0 served first giving 0x16161616, then req1 giving 0x52525252; continued valid alternates 0,1,0,1.
- Back-to-back: req0 valid for two words 0x53535353 then 0x00000000 → second ready coincides with the first RESP; results 0xedededed and 0x63636363 five cycles apart.
- Reset mid-op: assert `rst` at BUSY `cnt`=2 → no rsp pulse; `rsp_word`=0, `sbox_sub`=0 immediately; a post-reset request completes normally.
- Quiet: no valid for 20 cycles → `sbox_sub`=0, `sbox_in`=0, no ready, no rsp.
